// File: rtl/doppler_nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : doppler_nco_pkg
//  Description : Shared constants, types and elaboration-time helpers for the
//                multi-channel Doppler NCO (quadrant encoding, output
//                amplitude, quarter-wave sine table generator, dither LFSR).
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package doppler_nco_pkg;

  // Clocks from slot sample to registered output
  localparam int NCO_LATENCY = 2;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 and its reset seed
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // pi/2 in Q30, used by the table generator
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

  // Top two phase bits select the quadrant
  typedef enum logic [1:0] {
    QUAD_I   = 2'd0,
    QUAD_II  = 2'd1,
    QUAD_III = 2'd2,
    QUAD_IV  = 2'd3
  } quad_e;

  // Full-scale amplitude for a signed output of the given width
  function automatic int nco_amplitude(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // round(amp * sin(pi/2 * idx / 2^aw)) using integer-only Taylor series so
  // the table can be folded at elaboration without real-math support
  function automatic int nco_sin_entry(input int idx, input int aw, input int amp);
    longint x;
    longint term;
    longint acc;
    x    = (longint'(idx) * HALF_PI_Q30) >>> aw;
    term = x;
    acc  = x;
    for (int k = 1; k <= 10; k++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return int'((acc * longint'(amp) + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage : doppler_nco_pkg
`default_nettype wire

// File: rtl/nco_sincos_lut.sv
`default_nettype none
// ============================================================================
//  Module      : nco_sincos_lut
//  Description : Quarter-wave sine table with quadrant mirror/negate. Takes a
//                quadrant and in-quadrant address, produces registered signed
//                cos/sin one clock later. Outputs hold while en_i is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_sincos_lut
  import doppler_nco_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  quad_e                    quad_i,
  input  logic [LUT_AW-1:0]        addr_i,
  output logic signed [OUT_W-1:0]  cos_o,
  output logic signed [OUT_W-1:0]  sin_o
);

  localparam int              c_lut_n   = 1 << LUT_AW;
  localparam int              c_amp     = nco_amplitude(OUT_W);
  localparam logic [LUT_AW:0] c_lut_top = (LUT_AW + 1)'(c_lut_n);

  // One extra entry so that sin(pi/2) = full scale is exact at quadrant edges
  logic [OUT_W-2:0] w_lut [0:c_lut_n];

  for (genvar i = 0; i <= c_lut_n; i++) begin : g_lut
    localparam int c_val = nco_sin_entry(i, LUT_AW, c_amp);
    assign w_lut[i] = (OUT_W - 1)'(c_val);
  end

  logic [LUT_AW:0]         w_addr_fwd;
  logic [LUT_AW:0]         w_addr_rev;
  logic signed [OUT_W-1:0] w_mag_fwd;
  logic signed [OUT_W-1:0] w_mag_rev;
  logic signed [OUT_W-1:0] w_cos;
  logic signed [OUT_W-1:0] w_sin;
  logic signed [OUT_W-1:0] cos_q;
  logic signed [OUT_W-1:0] sin_q;

  assign w_addr_fwd = {1'b0, addr_i};
  assign w_addr_rev = c_lut_top - w_addr_fwd;
  assign w_mag_fwd  = signed'({1'b0, w_lut[w_addr_fwd]});
  assign w_mag_rev  = signed'({1'b0, w_lut[w_addr_rev]});

  // Fold the quarter wave into the selected quadrant
  always_comb begin
    w_cos = w_mag_rev;
    w_sin = w_mag_fwd;
    case (quad_i)
      QUAD_I:   begin w_cos =  w_mag_rev; w_sin =  w_mag_fwd; end
      QUAD_II:  begin w_cos = -w_mag_fwd; w_sin =  w_mag_rev; end
      QUAD_III: begin w_cos = -w_mag_rev; w_sin = -w_mag_fwd; end
      QUAD_IV:  begin w_cos =  w_mag_fwd; w_sin = -w_mag_rev; end
      default:  begin w_cos =  w_mag_rev; w_sin =  w_mag_fwd; end
    endcase
  end

  // Output register, updated only for valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (en_i) begin
      cos_q <= w_cos;
      sin_q <= w_sin;
    end
  end

  assign cos_o = cos_q;
  assign sin_o = sin_q;

endmodule : nco_sincos_lut
`default_nettype wire

// File: rtl/doppler_nco_mc.sv
`default_nettype none
// ============================================================================
//  Module      : doppler_nco_mc
//  Description : Time-multiplexed multi-channel Doppler NCO. One shared
//                accumulate + sin/cos path serves NUM_CH channels round-robin.
//                Frequencies are staged per channel and applied to all
//                channels together at the frame boundary after a commit.
//                Optional phase dither: define DOPPLER_NCO_DITHER_EN.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module doppler_nco_mc
  import doppler_nco_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 9,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [PHASE_W-1:0]       cfg_freq,
  input  logic                     cfg_phase_clr,
  input  logic                     commit,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  real_out,
  output logic signed [OUT_W-1:0]  imag_out
);

  localparam int              c_idx_w     = LUT_AW + 2;
  localparam logic [CH_W-1:0] c_last_slot = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] c_slot_one  = CH_W'(1);
  localparam logic [CH_W:0]   c_num_ch    = (CH_W + 1)'(NUM_CH);

  // Per-channel state
  logic [PHASE_W-1:0] phase_q    [NUM_CH];
  logic [PHASE_W-1:0] phase_d    [NUM_CH];
  logic [PHASE_W-1:0] freq_act_q [NUM_CH];
  logic [PHASE_W-1:0] freq_act_d [NUM_CH];
  logic [PHASE_W-1:0] freq_shd_q [NUM_CH];
  logic [PHASE_W-1:0] freq_shd_d [NUM_CH];
  logic [NUM_CH-1:0]  clr_shd_q;
  logic [NUM_CH-1:0]  clr_shd_d;
  logic [CH_W-1:0]    slot_q;
  logic [CH_W-1:0]    slot_d;
  logic               commit_pend_q;
  logic               commit_pend_d;

  // Sample pipeline
  logic               s1_valid_q;
  logic [CH_W-1:0]    s1_ch_q;
  logic [c_idx_w-1:0] s1_idx_q;
  logic               out_valid_q;
  logic [CH_W-1:0]    out_ch_q;

  logic               w_cfg_acc;
  logic               w_cfg_hit;
  logic               w_apply;
  logic [c_idx_w-1:0] w_samp_idx;

  assign cfg_ready = ~commit_pend_q;
  assign w_cfg_acc = cfg_valid & ~commit_pend_q;
  // Out-of-range channel writes are accepted but have no effect
  assign w_cfg_hit = w_cfg_acc & ({1'b0, cfg_ch} < c_num_ch);
  // Staged config lands on the last slot of a frame so the next frame is coherent
  assign w_apply   = enable & (slot_q == c_last_slot) & commit_pend_q;

`ifdef DOPPLER_NCO_DITHER_EN
  localparam int                 c_trunc_w    = PHASE_W - 2 - LUT_AW;
  localparam logic [PHASE_W-1:0] c_trunc_mask = (PHASE_W'(1) << c_trunc_w) - PHASE_W'(1);

  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic [PHASE_W-1:0] w_dither;
  logic [PHASE_W-1:0] w_dith_phase;

  // Dither LFSR steps once per enabled cycle
  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  // Dither LFSR register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Dither only perturbs the truncated bits of the sampled copy
  assign w_dither     = PHASE_W'(lfsr_q) & c_trunc_mask;
  assign w_dith_phase = phase_q[slot_q] + w_dither;
  assign w_samp_idx   = w_dith_phase[PHASE_W-1 -: c_idx_w];
`else
  assign w_samp_idx   = phase_q[slot_q][PHASE_W-1 -: c_idx_w];
`endif

  // Next state: slot advance, accumulate, staging, commit/apply
  always_comb begin
    slot_d        = slot_q;
    commit_pend_d = commit_pend_q;
    phase_d       = phase_q;
    freq_act_d    = freq_act_q;
    freq_shd_d    = freq_shd_q;
    clr_shd_d     = clr_shd_q;

    if (enable) begin
      slot_d = (slot_q == c_last_slot) ? '0 : slot_q + c_slot_one;
      phase_d[slot_q] = phase_q[slot_q] + freq_act_q[slot_q];
    end

    if (w_apply) begin
      commit_pend_d = 1'b0;
      freq_act_d    = freq_shd_q;
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_shd_q[c]) begin
          phase_d[c]   = '0;
          clr_shd_d[c] = 1'b0;
        end
      end
    end else if (commit) begin
      commit_pend_d = 1'b1;
    end

    // Accept and apply are mutually exclusive (accept needs no pending commit)
    if (w_cfg_hit) begin
      freq_shd_d[cfg_ch] = cfg_freq;
      clr_shd_d[cfg_ch]  = cfg_phase_clr;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        phase_q[c]    <= '0;
        freq_act_q[c] <= '0;
        freq_shd_q[c] <= '0;
      end
      clr_shd_q     <= '0;
      slot_q        <= '0;
      commit_pend_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      freq_act_q    <= freq_act_d;
      freq_shd_q    <= freq_shd_d;
      clr_shd_q     <= clr_shd_d;
      slot_q        <= slot_d;
      commit_pend_q <= commit_pend_d;
    end
  end

  // Stage 1: capture the pre-increment phase of the active slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= enable;
      if (enable) begin
        s1_ch_q  <= slot_q;
        s1_idx_q <= w_samp_idx;
      end
    end
  end

  // Stage 2: valid and channel tag travel alongside the LUT register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_ch_q <= s1_ch_q;
      end
    end
  end

  nco_sincos_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (s1_valid_q),
    .quad_i (quad_e'(s1_idx_q[c_idx_w-1 -: 2])),
    .addr_i (s1_idx_q[LUT_AW-1:0]),
    .cos_o  (real_out),
    .sin_o  (imag_out)
  );

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule : doppler_nco_mc
`default_nettype wire

// File: doc/doppler_nco_mc.md
# doppler_nco_mc

Parametrised, time-multiplexed multi-channel Doppler NCO for the GPS synthesizer, the multi-channel successor to the single-channel `doppler_nco`. One shared phase-accumulate/sin-cos datapath serves `NUM_CH` satellite channels round-robin, one channel per clock. Per-channel frequencies are staged through a config handshake and applied to all channels together at a frame boundary. Output is a tagged complex carrier sample stream feeding the per-channel code/carrier mixers.

## Interface
- `NUM_CH`, 4, number of channels (≥1); frame = `NUM_CH` cycles
- `PHASE_W`, 32, phase accumulator and frequency word width
- `LUT_AW`, 8, phase bits below the quadrant bits used as quarter-wave LUT address
- `OUT_W`, 9, signed output width; amplitude A = 2^(OUT_W-1)-1
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  advance slot counter and accumulators
- `cfg_valid`  in  1  staged-config write request
- `cfg_ready`  out  1  write accepted when `cfg_valid && cfg_ready`
- `cfg_ch`  in  max(1,$clog2(NUM_CH))  target channel
- `cfg_freq`  in  PHASE_W  phase increment per frame (unsigned, wraps)
- `cfg_phase_clr`  in  1  request phase zero for `cfg_ch` at commit
- `commit`  in  1  single-cycle pulse: apply all staged config at next boundary
- `out_valid`  out  1  sample valid
- `out_ch`  out  max(1,$clog2(NUM_CH))  channel of current sample
- `real_out`  out  OUT_W  signed cos(phase)·A
- `imag_out`  out  OUT_W  signed sin(phase)·A

## Operation
- State: `slot` counter, `phase[NUM_CH]`, `freq_act[NUM_CH]`, `freq_shd[NUM_CH]`, `clr_shd[NUM_CH]`, `commit_pend`.
- Reset: all arrays 0, `slot`=0, `commit_pend`=0; `cfg_ready`=1, `out_valid`=0, `out_ch`=0, `real_out`=`imag_out`=0.
- Each cycle with `enable`=1: sample `phase[slot]` (pre-increment value) into pipeline; write `phase[slot] <= phase[slot] + freq_act[slot]` mod 2^PHASE_W; `slot` increments, wraps `NUM_CH-1`→0.
- `enable`=0: slot, phases frozen; no new samples; pipeline drains (in-flight samples still emerge).
- Config: accepted write sets `freq_shd[cfg_ch]`, `clr_shd[cfg_ch] <= cfg_phase_clr`. `cfg_ch ≥ NUM_CH`: accepted, discarded.
- `cfg_ready = !commit_pend`. `commit` sets `commit_pend`; a write accepted in the same cycle as `commit` is included.
- Apply: cycle with `enable && slot==NUM_CH-1 && commit_pend`: `freq_act <= freq_shd`; for each ch with `clr_shd` set, `phase[ch] <= 0` (overrides that cycle's accumulate), `clr_shd[ch] <= 0`; `commit_pend <= 0`. Next frame uses new values for all channels.
- `commit` while `commit_pend`=1: ignored. `NUM_CH`=1: every enabled cycle is a boundary.
- Sin/cos: top 2 phase bits = quadrant, next `LUT_AW` bits = address; quarter-wave LUT with mirror/negate; remaining bits truncated. Positive freq = counter-clockwise (imag leads real by 90°).

## Timing
- Latency 2: slot sampled at cycle t → `out_valid`, `out_ch`, `real_out`, `imag_out` at t+2.
- Outputs registered; hold last value when `out_valid`=0.
- Commit latency: ≤ `NUM_CH` cycles from `commit` to apply, plus 2 to output.
- `rst_n` mid-operation: immediate return to reset values, pending commit and shadow config lost.

## Configuration
- `DOPPLER_NCO_DITHER_EN`: defined → 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset), advanced each enabled cycle, adds its low `PHASE_W-2-LUT_AW` bits to the sampled phase before truncation (accumulator unaffected). Undefined → plain truncation, bit-exact with LUT.

## Structure
- `doppler_nco_pkg`: `NCO_LATENCY`=2, quadrant enum, amplitude function of `OUT_W`, LFSR polynomial/seed constants.
- Sub-module `nco_sincos_lut`: quadrant + address in, registered signed cos/sin out (one cycle), LUT built at elaboration.

## Test plan
- Reset, freq 0, no commit, enable → all channels `real_out`=255, `imag_out`=0, `out_ch` 0,1,2,3 repeating, `out_valid` from 2 cycles after enable.
- ch0 freq 32'h40000000 + commit → ch0 samples cycle (255,0),(0,255),(-255,0),(0,-255) ±1 LSB per frame; other channels unchanged.
- Write ch1 freq, commit mid-frame → `cfg_ready` low until slot 3 apply cycle; old freq used through that frame, new freq from next; write during pending stalls.
- ch2 phase_clr + commit after 50 frames of freq 32'h01234567 → ch2 next sample (255,0).
- enable low 20 cycles mid-frame → two trailing samples then `out_valid`=0; resume continues same slot/phase with no skipped sample.
- `rst_n` pulse during pending commit → outputs zero, `cfg_ready`=1, freqs 0 after release.
